bg_write_arbiter: RTL and testbench

Time-shares the single write port of the background tile RAM between several tile writers: clear, ground/cliff, score, coin and text. It replaces fixed counter-sliced source selection with request/grant arbitration and bounded bursts. It sits between the game-engine tile generators and the background RAM port (`bg_ram_addr` / `bg_ram_data` / `bg_wea`).

---
 rtl/bg_arb_pkg.sv | 37 +++
 rtl/bg_write_arbiter_rr_picker.sv | 42 ++++
 rtl/bg_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_bg_write_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_arb_pkg.sv
// Shared definitions for the background tile RAM write arbiter.
package bg_arb_pkg;

    // Default background tile RAM geometry.
    localparam int unsigned BG_AW = 16;
    localparam int unsigned BG_DW = 32;

    // Arbiter FSM states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Tile-word field positions used by the tile writers.
    localparam int unsigned TILE_EN_BIT  = 8;
    localparam int unsigned TILE_FLIP_HI = 7;
    localparam int unsigned TILE_FLIP_LO = 6;
    localparam int unsigned TILE_ROW_HI  = 5;
    localparam int unsigned TILE_ROW_LO  = 3;
    localparam int unsigned TILE_COL_HI  = 2;
    localparam int unsigned TILE_COL_LO  = 0;

    // Assemble a 9-bit tile word from its fields.
    function automatic logic [8:0] tile_word(input logic       en,
                                             input logic [1:0] flip,
                                             input logic [2:0] row,
                                             input logic [2:0] col);
        logic [8:0] w;
        w = '0;
        w[TILE_EN_BIT]                = en;
        w[TILE_FLIP_HI:TILE_FLIP_LO]  = flip;
        w[TILE_ROW_HI:TILE_ROW_LO]    = row;
        w[TILE_COL_HI:TILE_COL_LO]    = col;
        return w;
    endfunction

endpackage

// File: rtl/bg_write_arbiter_rr_picker.sv
// Combinational round-robin picker with optional strict priority for
// requester 0. Shared by the RAM-sharing arbiters.
module rr_picker
    import bg_arb_pkg::*;
#(
    parameter int unsigned NREQ = 5,
    parameter int unsigned PTRW = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] rr_ptr,
    input  logic            prio0_en,
    output logic [NREQ-1:0] pick,
    output logic            valid
);

    // First set request searching upward from rr_ptr, wrapping to 0.
    always_comb begin
        logic [PTRW:0]   sum;
        logic [PTRW-1:0] idx;
        pick  = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        if (prio0_en && req[0]) begin
            pick[0] = 1'b1;
            valid   = 1'b1;
        end else begin
            for (int unsigned off = 0; off < NREQ; off++) begin
                sum = {1'b0, rr_ptr} + (PTRW+1)'(off);
                if (sum >= (PTRW+1)'(NREQ)) begin
                    sum = sum - (PTRW+1)'(NREQ);
                end
                idx = sum[PTRW-1:0];
                if (!valid && req[idx]) begin
                    pick[idx] = 1'b1;
                    valid     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bg_write_arbiter.sv
// Background tile RAM write-port arbiter: request/grant arbitration between
// tile writers with bounded bursts and a registered RAM write port.
module bg_write_arbiter
    import bg_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 5,
    parameter int unsigned AW        = BG_AW,
    parameter int unsigned DW        = BG_DW,
    parameter int unsigned MAX_BURST = 64,
    parameter int unsigned PRIO0     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      last,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   data,
    output logic [NREQ-1:0]      gnt,
    output logic                 bg_wea,
    output logic [AW-1:0]        bg_ram_addr,
    output logic [DW-1:0]        bg_ram_data,
    output logic                 busy
);

    localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW   = $clog2(MAX_BURST) + 1;

    arb_state_t      state, state_nxt;
    logic [PTRW-1:0] rr_ptr;
    logic [PTRW-1:0] gnt_idx;
    logic [PTRW-1:0] pick_idx;
    logic [PTRW-1:0] rr_nxt;
    logic [CW-1:0]   beat_cnt;
    logic [NREQ-1:0] pick;
    logic            pick_valid;
    logic            start;
    logic            beat;
    logic            rel;

    logic [AW-1:0] addr_arr [NREQ];
    logic [DW-1:0] data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign addr_arr[i] = addr[i*AW +: AW];
        assign data_arr[i] = data[i*DW +: DW];
    end

    rr_picker #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_picker (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .prio0_en (PRIO0 != 0),
        .pick     (pick),
        .valid    (pick_valid)
    );

    // Encode the one-hot pick into an index for the slice mux.
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                pick_idx = PTRW'(i);
            end
        end
    end

    assign rr_nxt = (gnt_idx == PTRW'(NREQ-1)) ? '0 : gnt_idx + PTRW'(1);
    assign busy   = (state == ST_BURST);

    // Next-state logic: grant in IDLE, accept beats and detect release in BURST.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        beat      = 1'b0;
        rel       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!hold && pick_valid) begin
                    start     = 1'b1;
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                beat = req[gnt_idx];
                // Deassert, last beat and burst-limit hit collapse into one release.
                if (!req[gnt_idx] || last[gnt_idx] ||
                    (beat_cnt == CW'(MAX_BURST-1))) begin
                    rel       = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant, round-robin pointer and beat counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt      <= '0;
            gnt_idx  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            if (start) begin
                gnt      <= pick;
                gnt_idx  <= pick_idx;
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
            if (rel) begin
                gnt    <= '0;
                rr_ptr <= rr_nxt;
            end
        end
    end

    // Registered RAM write port; address and data hold on non-beat cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bg_wea      <= 1'b0;
            bg_ram_addr <= '0;
            bg_ram_data <= '0;
        end else begin
            bg_wea <= beat;
            if (beat) begin
                bg_ram_addr <= addr_arr[gnt_idx];
                bg_ram_data <= data_arr[gnt_idx];
            end
        end
    end

endmodule

// File: tb/tb_bg_write_arbiter.sv
// Self-checking bench for bg_write_arbiter: directed scenarios plus a
// randomized run against a cycle-level reference model of the arbitration rules.
module tb_bg_write_arbiter;

    localparam int NREQ  = 5;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int MAXB  = 4;
    localparam int PRIO0 = 1;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                hold = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ-1:0]     last = '0;
    logic [NREQ*AW-1:0]  addr = '0;
    logic [NREQ*DW-1:0]  data = '0;
    logic [NREQ-1:0]     gnt;
    logic                bg_wea;
    logic [AW-1:0]       bg_ram_addr;
    logic [DW-1:0]       bg_ram_data;
    logic                busy;

    int n_cmp = 0;
    int n_bad = 0;

    bg_write_arbiter #(
        .NREQ      (NREQ),
        .AW        (AW),
        .DW        (DW),
        .MAX_BURST (MAXB),
        .PRIO0     (PRIO0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold),
        .req         (req),
        .last        (last),
        .addr        (addr),
        .data        (data),
        .gnt         (gnt),
        .bg_wea      (bg_wea),
        .bg_ram_addr (bg_ram_addr),
        .bg_ram_data (bg_ram_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Tile writer sources: remaining beats, beat sequence number, address base.
    int src_rem    [NREQ];
    int src_seq    [NREQ];
    int src_base   [NREQ];
    bit src_pause  [NREQ];
    bit src_nolast [NREQ];
    bit src_lastall[NREQ];
    int wseq       [NREQ];

    // Reference model: m_g is the grantee (-1 when idle).
    int              m_g = -1;
    int              m_rr = 0;
    int              m_cnt = 0;
    logic [NREQ-1:0] m_gnt = '0;
    logic            m_wea = 1'b0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_data = '0;

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i]  = (src_rem[i] > 0) && !src_pause[i];
            last[i] = src_lastall[i] || (src_rem[i] == 1 && !src_nolast[i]);
            addr[i*AW +: AW] = AW'(src_base[i] + src_seq[i]);
            data[i*DW +: DW] = {8'(i), 24'(src_seq[i])};
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NREQ; i++) begin
            src_rem[i] = 0; src_seq[i] = 0; src_base[i] = 0;
            src_pause[i] = 0; src_nolast[i] = 0; src_lastall[i] = 0;
            wseq[i] = 0;
        end
    endtask

    // Advance model and DUT by one clock; sources advance on accepted beats.
    task automatic tick();
        int acc;
        int w;
        int k;
        acc = -1;
        if (!reset) begin
            m_g = -1; m_rr = 0; m_cnt = 0;
            m_gnt = '0; m_wea = 1'b0; m_addr = '0; m_data = '0;
        end else if (m_g < 0) begin
            m_wea = 1'b0;
            if (!hold && req != '0) begin
                w = -1;
                if (PRIO0 != 0 && req[0]) w = 0;
                for (int j = 0; j < NREQ; j++) begin
                    k = (m_rr + j) % NREQ;
                    if (w < 0 && req[k]) w = k;
                end
                m_g = w; m_cnt = 0;
                m_gnt = '0; m_gnt[w] = 1'b1;
            end
        end else begin
            if (req[m_g]) begin
                acc    = m_g;
                m_wea  = 1'b1;
                m_addr = addr[m_g*AW +: AW];
                m_data = data[m_g*DW +: DW];
                m_cnt++;
            end else begin
                m_wea = 1'b0;
            end
            if (!req[m_g] || last[m_g] || m_cnt == MAXB) begin
                m_rr  = (m_g + 1) % NREQ;
                m_g   = -1;
                m_gnt = '0;
            end
        end
        @(posedge clk);
        #1;
        if (acc >= 0) begin
            src_seq[acc]++;
            src_rem[acc]--;
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        hold  = 1'b0;
        clear_sources();
        drive();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (gnt !== '0)    begin n_bad++; $display("FAIL reset_gnt got %b want 0", gnt); end
        n_cmp++; if (bg_wea !== 0)  begin n_bad++; $display("FAIL reset_wea got %b want 0", bg_wea); end
        n_cmp++; if (bg_ram_addr !== '0) begin n_bad++; $display("FAIL reset_addr got %h want 0", bg_ram_addr); end
        n_cmp++; if (bg_ram_data !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", bg_ram_data); end
        n_cmp++; if (busy !== 0)    begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        // Reset in the cycle after a beat was accepted, mid-burst.
        src_rem[3] = 5; src_base[3] = 500; drive();
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (gnt !== '0)    begin n_bad++; $display("FAIL midrst_gnt got %b want 0", gnt); end
        n_cmp++; if (bg_wea !== 0)  begin n_bad++; $display("FAIL midrst_wea got %b want 0", bg_wea); end
        n_cmp++; if (bg_ram_addr !== '0 || bg_ram_data !== '0) begin
            n_bad++; $display("FAIL midrst_port got %h/%h want 0/0", bg_ram_addr, bg_ram_data); end
        n_cmp++; if (busy !== 0)    begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_cmp++; if (dut.rr_ptr !== '0) begin n_bad++; $display("FAIL midrst_rrptr got %0d want 0", dut.rr_ptr); end
        reset = 1'b1;
        tick();
        n_cmp++; if (gnt !== 5'b01000) begin n_bad++; $display("FAIL midrst_regrant got %b want 01000", gnt); end
        n_cmp++; if (bg_wea !== 0) begin n_bad++; $display("FAIL midrst_nowrite got %b want 0", bg_wea); end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] eg [5] = '{5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00000};
        logic            ew [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int              ea [5] = '{0, 1080, 1081, 1082, 0};
        do_reset();
        src_rem[2] = 3; src_base[2] = 1080; drive();
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (gnt !== eg[c]) begin
                n_bad++; $display("FAIL single_gnt c%0d got %b want %b", c+1, gnt, eg[c]); end
            n_cmp++; if (bg_wea !== ew[c]) begin
                n_bad++; $display("FAIL single_wea c%0d got %b want %b", c+1, bg_wea, ew[c]); end
            if (ew[c]) begin
                n_cmp++; if (bg_ram_addr !== AW'(ea[c])) begin
                    n_bad++; $display("FAIL single_addr c%0d got %0d want %0d", c+1, bg_ram_addr, ea[c]); end
            end
        end
    endtask

    task automatic test_round_robin();
        int order [6] = '{1, 2, 4, 1, 2, 4};
        logic [NREQ-1:0] want;
        do_reset();
        foreach (order[i]) ;
        src_rem[1] = 100; src_rem[2] = 100; src_rem[4] = 100;
        src_lastall[1] = 1; src_lastall[2] = 1; src_lastall[4] = 1;
        drive();
        for (int c = 0; c < 12; c++) begin
            tick();
            want = '0;
            if (c % 2 == 0) want[order[c/2]] = 1'b1;
            n_cmp++; if (gnt !== want) begin
                n_bad++; $display("FAIL rr_gnt c%0d got %b want %b", c+1, gnt, want); end
        end
    endtask

    task automatic test_priority();
        do_reset();
        src_rem[3] = 3; src_base[3] = 300; drive();
        tick();
        tick();
        src_rem[0] = 1; src_rem[1] = 1; src_rem[4] = 1; drive();
        n_cmp++; if (gnt !== 5'b01000) begin n_bad++; $display("FAIL prio_mid c2 got %b want 01000", gnt); end
        tick();
        n_cmp++; if (gnt !== 5'b01000) begin n_bad++; $display("FAIL prio_finish c3 got %b want 01000", gnt); end
        tick();
        n_cmp++; if (gnt !== 5'b00000) begin n_bad++; $display("FAIL prio_bubble c4 got %b want 00000", gnt); end
        tick();
        n_cmp++; if (gnt !== 5'b00001) begin n_bad++; $display("FAIL prio_clear c5 got %b want 00001", gnt); end
        tick();
        tick();
        n_cmp++; if (gnt !== 5'b00010) begin n_bad++; $display("FAIL prio_next c7 got %b want 00010", gnt); end
    endtask

    task automatic test_max_burst();
        int got [$];
        do_reset();
        src_rem[1] = 10; src_nolast[1] = 1; src_base[1] = 2000; drive();
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bg_wea) got.push_back(int'(bg_ram_addr));
            if (c == 5 || c == 10) begin
                n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL maxb_release c%0d got %b want 0", c, gnt); end
            end
            if (c == 6 || c == 11) begin
                n_cmp++; if (gnt !== 5'b00010) begin n_bad++; $display("FAIL maxb_regrant c%0d got %b want 00010", c, gnt); end
            end
        end
        n_cmp++; if (got.size() != 10) begin n_bad++; $display("FAIL maxb_count got %0d want 10", got.size()); end
        for (int k = 0; k < got.size() && k < 10; k++) begin
            n_cmp++; if (got[k] != 2000 + k) begin
                n_bad++; $display("FAIL maxb_order beat%0d got %0d want %0d", k, got[k], 2000 + k); end
        end
    endtask

    task automatic test_hold();
        logic [NREQ-1:0] eg [5] = '{5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
        do_reset();
        hold = 1'b1;
        src_rem[0] = 3; src_base[0] = 100;
        src_rem[1] = 1; src_base[1] = 200;
        drive();
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (gnt !== '0 || busy !== 0) begin
                n_bad++; $display("FAIL hold_idle c%0d got gnt=%b busy=%b want 0/0", c, gnt, busy); end
        end
        hold = 1'b0;
        tick();
        n_cmp++; if (gnt !== 5'b00001) begin n_bad++; $display("FAIL hold_release got %b want 00001", gnt); end
        hold = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (gnt !== eg[c]) begin
                n_bad++; $display("FAIL hold_midburst c%0d got %b want %b", c, gnt, eg[c]); end
        end
        hold = 1'b0;
        tick();
        n_cmp++; if (gnt !== 5'b00010) begin n_bad++; $display("FAIL hold_after got %b want 00010", gnt); end
    endtask

    task automatic test_random();
        int s;
        int sq;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (src_rem[i] == 0 && $urandom_range(0, 7) == 0) begin
                    src_rem[i]    = $urandom_range(1, 7);
                    src_nolast[i] = ($urandom_range(0, 3) == 0);
                    src_base[i]   = $urandom_range(0, 16'hF000);
                end
                src_pause[i] = ($urandom_range(0, 15) == 0);
            end
            hold = ($urandom_range(0, 9) == 0);
            drive();
            tick();
            n_cmp++; if (gnt !== m_gnt || busy !== (m_g >= 0)) begin
                n_bad++; $display("FAIL rand_gnt c%0d got %b/%b want %b/%b", c, gnt, busy, m_gnt, m_g >= 0); end
            n_cmp++; if (bg_wea !== m_wea || bg_ram_addr !== m_addr || bg_ram_data !== m_data) begin
                n_bad++; $display("FAIL rand_port c%0d got %b %h %h want %b %h %h", c,
                                  bg_wea, bg_ram_addr, bg_ram_data, m_wea, m_addr, m_data); end
            n_cmp++; if ($countones(gnt) > 1) begin
                n_bad++; $display("FAIL rand_onehot c%0d got %b want at most one bit", c, gnt); end
            if (bg_wea === 1'b1) begin
                s  = int'(bg_ram_data[31:24]);
                sq = int'(bg_ram_data[23:0]);
                if (s < NREQ) begin
                    n_cmp++; if (sq != wseq[s]) begin
                        n_bad++; $display("FAIL rand_order src%0d got seq %0d want %0d", s, sq, wseq[s]); end
                    wseq[s] = sq + 1;
                end else begin
                    n_cmp++; n_bad++;
                    $display("FAIL rand_src got %0d want below %0d", s, NREQ);
                end
            end
        end
        hold = 1'b0;
    endtask

    initial begin
        clear_sources();
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_max_burst();
        test_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
